// File: rtl/csla_seq_add32_pkg.sv
// Shared constants for the sequential carry-select adder: FSM encodings,
// slice width and the idx counter sizing helper.
package csla_seq_add32_pkg;

   localparam int SLICE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // A single-slice adder still needs a 1-bit idx so the counter is never zero-width.
   function automatic int idx_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/csla_bec8.sv
// 8-bit carry-select slice: the low nibble ripples, the high nibble is
// precomputed for carry 0 and incremented by a binary-to-excess-1 converter.
module csla_bec8
   import csla_seq_add32_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [3:0] lo_sum;
   logic       lo_carry;
   logic [4:0] hi_c0;
   logic [4:0] hi_c1;

   always_comb begin
      logic c;
      c = cin;
      lo_sum = '0;
      for (int i = 0; i < 4; i++) begin
         lo_sum[i] = a[i] ^ b[i] ^ c;
         c         = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      lo_carry = c;
   end

   always_comb begin
      logic c;
      c = 1'b0;
      hi_c0 = '0;
      for (int i = 0; i < 4; i++) begin
         hi_c0[i] = a[i+4] ^ b[i+4] ^ c;
         c        = (a[i+4] & b[i+4]) | (c & (a[i+4] ^ b[i+4]));
      end
      hi_c0[4] = c;
   end

   // Excess-1 of the carry-0 result: each bit flips when all lower bits are 1.
   always_comb begin
      logic run;
      run = 1'b1;
      hi_c1 = '0;
      for (int i = 0; i < 5; i++) begin
         hi_c1[i] = hi_c0[i] ^ run;
         run      = run & hi_c0[i];
      end
   end

   assign sum  = {(lo_carry ? hi_c1[3:0] : hi_c0[3:0]), lo_sum};
   assign cout = lo_carry ? hi_c1[4] : hi_c0[4];

endmodule

// File: rtl/csla_seq_add32.sv
// WIDTH-bit adder built by stepping one csla_bec8 slice across the operands,
// least-significant slice first, with the inter-slice carry held in a register.
module csla_seq_add32
   import csla_seq_add32_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   // WIDTH must be a multiple of SLICE_W; any remainder bits would be dropped.
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = idx_width(NSLICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef struct packed {
      logic [1:0]       state;
      logic [IDX_W-1:0] idx;
   } ctrl_t;

   ctrl_t                            ctrl;
   logic                             carry;
   logic                             cout_reg;
   logic [NSLICE-1:0][SLICE_W-1:0]   a_reg;
   logic [NSLICE-1:0][SLICE_W-1:0]   b_reg;
   logic [NSLICE-1:0][SLICE_W-1:0]   sum_reg;
   logic [SLICE_W-1:0]               slice_sum;
   logic                             slice_cout;

   csla_bec8 u_slice (
      .a    (a_reg[ctrl.idx]),
      .b    (b_reg[ctrl.idx]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid never depends on ready, and rst overrides any transfer.
   // Operands are taken only in IDLE, results offered only in DONE, so an
   // input and an output transfer can never share an edge.
   assign in_ready  = (ctrl.state == ST_IDLE);
   assign busy      = (ctrl.state == ST_RUN);
   assign out_valid = (ctrl.state == ST_DONE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl     <= '{state: ST_IDLE, idx: '0};
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
      end else begin
         case (ctrl.state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  carry      <= cin;
                  sum_reg    <= '0;
                  cout_reg   <= 1'b0;
                  ctrl.idx   <= '0;
                  ctrl.state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_reg[ctrl.idx] <= slice_sum;
               carry             <= slice_cout;
               if (ctrl.idx == LAST_IDX) begin
                  cout_reg   <= slice_cout;
                  ctrl.idx   <= '0;
                  ctrl.state <= ST_DONE;
               end else begin
                  ctrl.idx <= ctrl.idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  ctrl.state <= ST_IDLE;
               end
            end
            default: begin
               ctrl <= '{state: ST_IDLE, idx: '0};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csla_seq_add32.sv
// Self-checking bench for csla_seq_add32: directed vectors with literal results,
// randomized operands, and a latency-level model compared on every cycle.
module tb_csla_seq_add32;

   localparam int WIDTH  = 32;
   localparam int NSLICE = WIDTH / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   csla_seq_add32 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] last_res;
   int             n_vec     = 0;
   int             n_miss    = 0;
   int             cyc       = 0;
   int             t_acc     = 0;
   bit             model_ok  = 1'b0;
   bit             in_flight = 1'b0;
   bit             done_now;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Model: an accepted add is in flight for NSLICE cycles, then its result
   // is offered until taken; nothing is accepted while one is in flight.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         model_ok  = 1'b1;
         in_flight = 1'b0;
         last_res  = '0;
         exp_q.delete();
      end else if (model_ok) begin
         if (in_flight) begin
            if ((cyc - 1 - t_acc) >= NSLICE && out_ready) begin
               last_res  = exp_q.pop_front();
               in_flight = 1'b0;
            end
         end else if (in_valid) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
            t_acc     = cyc;
            in_flight = 1'b1;
            last_res  = '0;
         end
      end
   end

   // Per-cycle compare of all outputs against the model.
   always @(negedge clk) begin
      if (model_ok) begin
         done_now = in_flight && ((cyc - t_acc) >= NSLICE);
         check("in_ready", in_ready, !in_flight);
         check("busy", busy, in_flight && !done_now);
         check("out_valid", out_valid, done_now);
         if (done_now && exp_q.size() > 0)
            check("result", {cout, sum}, exp_q[0]);
         else if (!in_flight)
            check("held_result", {cout, sum}, last_res);
         else if (cyc == t_acc)
            check("cleared_on_accept", {cout, sum}, 64'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vc, output int acc_edge);
      int n;
      a        = va;
      b        = vb;
      cin      = vc;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", in_ready, 1);
      acc_edge = -1;
      if (in_ready) begin
         @(posedge clk);
         @(negedge clk);
         acc_edge = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input int acc_edge, input int hold,
                          input logic [WIDTH:0] req, input string tag);
      int n;
      out_ready = 1'b0;
      n         = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      if (acc_edge >= 0)
         check({tag, "_latency"}, cyc - acc_edge + 1, NSLICE + 1);
      check({tag, "_sum"}, {cout, sum}, req);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, "_held_valid"}, out_valid, 1);
         check({tag, "_held_sum"}, {cout, sum}, req);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ready_after"}, in_ready, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int             e;
      int             prev;
      int             n;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic           rc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", {cout, sum}, 64'd0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      send(32'h000000FF, 32'h00000001, 1'b0, e);
      collect(e, 0, 33'h0_00000100, "carry8");

      send(32'hFFFFFFFF, 32'h00000000, 1'b1, e);
      collect(e, 0, 33'h1_00000000, "ripple_all");

      send(32'h12345678, 32'h9ABCDEF0, 1'b0, e);
      collect(e, 10, 33'h0_ACF13568, "backpressure");

      send(32'h80000000, 32'h80000000, 1'b0, e);
      a        = $urandom;
      b        = $urandom;
      cin      = 1'b1;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      collect(e, 0, 33'h1_00000000, "ignore_in_run");

      send(32'hFFFF0000, 32'h0001FFFF, 1'b0, e);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_sum", {cout, sum}, 64'd0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      send(32'h00000001, 32'h00000001, 1'b0, e);
      collect(e, 0, 33'h0_00000002, "after_abort");

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      prev      = -1;
      for (int i = 0; i < 3; i++) begin
         a        = $urandom;
         b        = $urandom;
         cin      = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         n        = 0;
         while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("b2b_ready", in_ready, 1);
         @(posedge clk);
         @(negedge clk);
         e = cyc;
         if (prev >= 0)
            check("b2b_spacing", e - prev, NSLICE + 2);
         prev = e;
      end
      in_valid = 1'b0;
      repeat (NSLICE + 3) @(negedge clk);
      out_ready = 1'b0;
      check("b2b_drained", in_ready, 1);

      // Randomized operands with random backpressure.
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         if (i == 0) begin
            ra = '1;
            rb = '1;
            rc = 1'b1;
         end
         send(ra, rb, rc, e);
         collect(e, $urandom_range(0, 3), {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc}, "random");
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
